usb_rx_data_unpack: RTL and testbench

- Sits directly downstream of the DP/DM line decoder in the receive path.
- Consumes the raw line-level bit stream (in_bit) for the duration of a DATA0 payload, framed by in_valid; eop marks end of packet.
- Performs NRZI decode, bit unstuffing, serial CRC16 check and LSB-first assembly of the 64-bit payload.
- Reports payload, CRC status and framing errors to the protocol FSM via a one-cycle result strobe.

---
 rtl/usb_rx_pkg.sv | 27 ++
 rtl/crc16_serial.sv | 30 +++
 rtl/usb_rx_data_unpack.sv | 132 +++++++++++++
 tb/tb_usb_rx_data_unpack.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/usb_rx_pkg.sv
// Shared constants and types for the USB receive data path.
// Pure definitions, no latency.
// No flow control of its own.
package usb_rx_pkg;

  localparam int DATA_BITS = 64;
  localparam int CRC_BITS  = 16;

  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  // A complemented CRC16 appended MSB-first drives the register to this value.
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_t;

  // One serial CRC16 step for a single input bit.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC16 register (poly 0x8005), shared by the RX checker and TX generator.
// One bit per enabled cycle; crc reflects all bits up to the previous edge.
// No backpressure; clear has priority over en.
module crc16_serial
  import usb_rx_pkg::*;
(
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  // Shift register: reload on clear, advance one bit on en, otherwise hold.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_crc <= CRC16_INIT;
    end else if (clear) begin
      r_crc <= CRC16_INIT;
    end else if (en) begin
      r_crc <= crc16_next(r_crc, bit_in);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/usb_rx_data_unpack.sv
// NRZI decode, bit unstuff, CRC16 check and LSB-first assembly of a DATA0 payload.
// Result strobe (data_valid) one cycle after the eop cycle; results held until next packet.
// No backpressure: one line bit per cycle while in_valid, in_valid low simply pauses.
module usb_rx_data_unpack
  import usb_rx_pkg::*;
#(
  parameter int DATA_BITS = usb_rx_pkg::DATA_BITS,
  parameter int CRC_BITS  = usb_rx_pkg::CRC_BITS
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_bit,
  input  logic                 in_valid,
  input  logic                 eop,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 crc_ok,
  output logic                 stuff_err,
  output logic                 len_err
);

  localparam int TOTAL = DATA_BITS + CRC_BITS;
  // Counter saturates one past the expected length so overruns stay visible.
  localparam int SAT   = TOTAL + 1;
  localparam int CNT_W = $clog2(SAT + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  state_t           r_state;
  logic             r_prev_line;
  logic [2:0]       r_ones_cnt;
  logic [CNT_W-1:0] r_bit_cnt;

  logic             w_dec;
  logic             w_active;
  logic             w_stuff_slot;
  logic             w_real_bit;
  logic             w_in_data;
  logic [IDX_W-1:0] w_wr_idx;
  logic             w_len_err_fin;
  logic             w_crc_clr;
  logic             w_crc_en;
  logic [15:0]      w_crc;

  // NRZI: no transition on the line means a decoded one.
  assign w_dec         = (in_bit == r_prev_line);
  assign w_active      = (r_state == RECV) && in_valid && !eop;
  // After six consecutive ones the next bit is a stuff bit and never payload.
  assign w_stuff_slot  = (r_ones_cnt == 3'd6);
  assign w_real_bit    = w_active && !w_stuff_slot;
  assign w_in_data     = (r_bit_cnt < CNT_W'(DATA_BITS));
  assign w_wr_idx      = r_bit_cnt[IDX_W-1:0];
  assign w_len_err_fin = len_err || (r_bit_cnt != CNT_W'(TOTAL));
  assign w_crc_clr     = (r_state == IDLE) && in_valid && !eop;
  assign w_crc_en      = w_real_bit;

  crc16_serial u_crc (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (w_crc_clr),
    .en      (w_crc_en),
    .bit_in  (w_dec),
    .crc     (w_crc)
  );

  // Packet FSM with all result outputs registered.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_prev_line <= 1'b1;
      r_ones_cnt  <= 3'd0;
      r_bit_cnt   <= '0;
      data_out    <= '0;
      data_valid  <= 1'b0;
      crc_ok      <= 1'b0;
      stuff_err   <= 1'b0;
      len_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          // The first in_valid cycle is the final PID bit: it only seeds the NRZI reference.
          if (in_valid && !eop) begin
            r_state     <= RECV;
            r_prev_line <= in_bit;
            r_ones_cnt  <= 3'd0;
            r_bit_cnt   <= '0;
            data_out    <= '0;
            crc_ok      <= 1'b0;
            stuff_err   <= 1'b0;
            len_err     <= 1'b0;
          end
        end
        RECV: begin
          if (eop) begin
            r_state    <= DONE;
            data_valid <= 1'b1;
            len_err    <= w_len_err_fin;
            crc_ok     <= (w_crc == CRC16_RESIDUAL) && !w_len_err_fin && !stuff_err;
          end else if (in_valid) begin
            r_prev_line <= in_bit;
            if (w_stuff_slot) begin
              // A one where a stuff zero belongs is a framing error; drop the bit either way.
              r_ones_cnt <= 3'd0;
              if (w_dec) begin
                stuff_err <= 1'b1;
              end
            end else begin
              r_ones_cnt <= w_dec ? (r_ones_cnt + 3'd1) : 3'd0;
              if (w_in_data) begin
                data_out[w_wr_idx] <= w_dec;
              end
              if (r_bit_cnt != CNT_W'(SAT)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (r_bit_cnt == CNT_W'(SAT - 1)) begin
                  len_err <= 1'b1;
                end
              end
            end
          end
        end
        DONE: begin
          r_prev_line <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_data_unpack.sv
module tb_usb_rx_data_unpack;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_bit = 1'b1;
  logic        in_valid = 1'b0;
  logic        eop = 1'b0;
  logic [63:0] data_out;
  logic        data_valid;
  logic        crc_ok;
  logic        stuff_err;
  logic        len_err;

  int n_checks = 0;
  int n_fail = 0;

  bit bits_q[$];
  bit line_q[$];

  logic        obs_dv_early, obs_dv, obs_dv_after;
  logic [63:0] obs_data;
  logic        obs_crc, obs_stuff, obs_len;

  always #5 clock = ~clock;

  usb_rx_data_unpack dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_bit     (in_bit),
    .in_valid   (in_valid),
    .eop        (eop),
    .data_out   (data_out),
    .data_valid (data_valid),
    .crc_ok     (crc_ok),
    .stuff_err  (stuff_err),
    .len_err    (len_err)
  );

  // Unstuffed bit list: payload LSB first, then complemented CRC16 MSB first.
  task automatic make_bits(input logic [63:0] p);
    logic [15:0] c;
    bit b, fb;
    bits_q.delete();
    c = 16'hFFFF;
    for (int i = 0; i < 64; i++) begin
      b = p[i];
      bits_q.push_back(b);
      fb = b ^ c[15];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    for (int i = 15; i >= 0; i--) bits_q.push_back(~c[i]);
  endtask

  // Bit stuffing plus NRZI line encoding, starting from J after the PID.
  task automatic encode(input bit skip_first_stuff);
    bit level, skipped;
    int ones;
    line_q.delete();
    level = 1'b1;
    ones = 0;
    skipped = 1'b0;
    foreach (bits_q[i]) begin
      if (bits_q[i]) ones++;
      else begin level = ~level; ones = 0; end
      line_q.push_back(level);
      if (ones == 6) begin
        if (skip_first_stuff && !skipped) skipped = 1'b1;
        else begin level = ~level; line_q.push_back(level); end
        ones = 0;
      end
    end
  endtask

  task automatic send_packet(input int gap_at, input int gap_len);
    @(posedge clock); #1;
    in_valid = 1'b1; in_bit = 1'b1; eop = 1'b0;
    for (int i = 0; i < line_q.size(); i++) begin
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          @(posedge clock); #1;
          in_valid = 1'b0; in_bit = ~in_bit;
        end
      end
      @(posedge clock); #1;
      in_valid = 1'b1; in_bit = line_q[i];
    end
    @(posedge clock); #1;
    in_valid = 1'b0; eop = 1'b1;
    @(negedge clock);
    obs_dv_early = data_valid;
    @(posedge clock); #1;
    eop = 1'b0;
    @(negedge clock);
    obs_dv = data_valid; obs_data = data_out;
    obs_crc = crc_ok; obs_stuff = stuff_err; obs_len = len_err;
    @(negedge clock);
    obs_dv_after = data_valid;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (data_out !== 64'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv: got %b exp 0", data_valid); end
    n_checks++; if (crc_ok !== 1'b0) begin n_fail++; $display("FAIL reset_crc_ok: got %b exp 0", crc_ok); end
    n_checks++; if (stuff_err !== 1'b0) begin n_fail++; $display("FAIL reset_stuff: got %b exp 0", stuff_err); end
    n_checks++; if (len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len: got %b exp 0", len_err); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clock);
  endtask

  task automatic test_basic();
    make_bits(64'h0000_0000_0000_0001); encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_dv_early !== 1'b0) begin n_fail++; $display("FAIL basic_dv_eop_cycle: got %b exp 0", obs_dv_early); end
    n_checks++; if (obs_dv !== 1'b1) begin n_fail++; $display("FAIL basic_dv: got %b exp 1", obs_dv); end
    n_checks++; if (obs_data !== 64'h1) begin n_fail++; $display("FAIL basic_data: got %h exp %h", obs_data, 64'h1); end
    n_checks++; if (obs_crc !== 1'b1) begin n_fail++; $display("FAIL basic_crc_ok: got %b exp 1", obs_crc); end
    n_checks++; if (obs_stuff !== 1'b0) begin n_fail++; $display("FAIL basic_stuff: got %b exp 0", obs_stuff); end
    n_checks++; if (obs_len !== 1'b0) begin n_fail++; $display("FAIL basic_len: got %b exp 0", obs_len); end
    n_checks++; if (obs_dv_after !== 1'b0) begin n_fail++; $display("FAIL basic_dv_one_cycle: got %b exp 0", obs_dv_after); end
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (data_out !== 64'h1 || crc_ok !== 1'b1) begin n_fail++; $display("FAIL basic_hold: got %h/%b exp 1/1", data_out, crc_ok); end
  endtask

  task automatic test_stuffing();
    make_bits(64'h0000_0000_0000_00FF); encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_data !== 64'hFF) begin n_fail++; $display("FAIL stuff_data: got %h exp %h", obs_data, 64'hFF); end
    n_checks++; if (obs_crc !== 1'b1) begin n_fail++; $display("FAIL stuff_crc_ok: got %b exp 1", obs_crc); end
    n_checks++; if (obs_stuff !== 1'b0) begin n_fail++; $display("FAIL stuff_err_clean: got %b exp 0", obs_stuff); end
    make_bits(64'h0000_0000_0000_00FF); encode(1'b1); send_packet(-1, 0);
    n_checks++; if (obs_dv !== 1'b1) begin n_fail++; $display("FAIL nostuff_dv: got %b exp 1", obs_dv); end
    n_checks++; if (obs_stuff !== 1'b1) begin n_fail++; $display("FAIL nostuff_err: got %b exp 1", obs_stuff); end
    n_checks++; if (obs_crc !== 1'b0) begin n_fail++; $display("FAIL nostuff_crc_ok: got %b exp 0", obs_crc); end
  endtask

  task automatic test_bad_crc();
    make_bits(64'h0123_4567_89AB_CDEF);
    bits_q[64 + 12] = ~bits_q[64 + 12];
    encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_dv !== 1'b1) begin n_fail++; $display("FAIL badcrc_dv: got %b exp 1", obs_dv); end
    n_checks++; if (obs_data !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("FAIL badcrc_data: got %h exp %h", obs_data, 64'h0123_4567_89AB_CDEF); end
    n_checks++; if (obs_crc !== 1'b0) begin n_fail++; $display("FAIL badcrc_crc_ok: got %b exp 0", obs_crc); end
    n_checks++; if (obs_len !== 1'b0) begin n_fail++; $display("FAIL badcrc_len: got %b exp 0", obs_len); end
  endtask

  task automatic test_length();
    make_bits(64'h0000_0000_0000_0001);
    void'(bits_q.pop_back());
    encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_len !== 1'b1) begin n_fail++; $display("FAIL short_len: got %b exp 1", obs_len); end
    n_checks++; if (obs_crc !== 1'b0) begin n_fail++; $display("FAIL short_crc_ok: got %b exp 0", obs_crc); end
    make_bits(64'hA5A5_0F0F_1234_5678);
    bits_q.push_back(1'b0); bits_q.push_back(1'b0);
    encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_len !== 1'b1) begin n_fail++; $display("FAIL long_len: got %b exp 1", obs_len); end
    n_checks++; if (obs_data !== 64'hA5A5_0F0F_1234_5678) begin n_fail++; $display("FAIL long_data: got %h exp %h", obs_data, 64'hA5A5_0F0F_1234_5678); end
    n_checks++; if (obs_crc !== 1'b0) begin n_fail++; $display("FAIL long_crc_ok: got %b exp 0", obs_crc); end
  endtask

  task automatic test_gap();
    make_bits(64'h0000_0000_0000_0001); encode(1'b0); send_packet(30, 3);
    n_checks++; if (obs_dv !== 1'b1) begin n_fail++; $display("FAIL gap_dv: got %b exp 1", obs_dv); end
    n_checks++; if (obs_data !== 64'h1) begin n_fail++; $display("FAIL gap_data: got %h exp %h", obs_data, 64'h1); end
    n_checks++; if (obs_crc !== 1'b1) begin n_fail++; $display("FAIL gap_crc_ok: got %b exp 1", obs_crc); end
    n_checks++; if (obs_len !== 1'b0 || obs_stuff !== 1'b0) begin n_fail++; $display("FAIL gap_errs: got len=%b stuff=%b exp 0/0", obs_len, obs_stuff); end
  endtask

  task automatic test_eop_idle();
    logic seen;
    seen = 1'b0;
    @(posedge clock); #1;
    eop = 1'b1;
    @(posedge clock); #1;
    eop = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (data_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL idle_eop_dv: got %b exp 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic seen;
    seen = 1'b0;
    make_bits(64'hFFFF_0000_FFFF_0000); encode(1'b0);
    @(posedge clock); #1;
    in_valid = 1'b1; in_bit = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      in_bit = line_q[i];
    end
    reset_n = 1'b0;
    #1;
    n_checks++; if (data_out !== 64'h0 || crc_ok !== 1'b0 || stuff_err !== 1'b0 || len_err !== 1'b0 || data_valid !== 1'b0)
      begin n_fail++; $display("FAIL midrst_outputs: got %h %b %b %b %b exp all 0", data_out, crc_ok, stuff_err, len_err, data_valid); end
    in_valid = 1'b0; eop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (data_valid) seen = 1'b1;
    end
    @(posedge clock); #1;
    eop = 1'b0; reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (data_valid) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_dv: got %b exp 0", seen); end
    make_bits(64'hDEAD_BEEF_0123_4567); encode(1'b0); send_packet(-1, 0);
    n_checks++; if (obs_dv !== 1'b1) begin n_fail++; $display("FAIL postrst_dv: got %b exp 1", obs_dv); end
    n_checks++; if (obs_data !== 64'hDEAD_BEEF_0123_4567) begin n_fail++; $display("FAIL postrst_data: got %h exp %h", obs_data, 64'hDEAD_BEEF_0123_4567); end
    n_checks++; if (obs_crc !== 1'b1) begin n_fail++; $display("FAIL postrst_crc_ok: got %b exp 1", obs_crc); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuffing();
    test_bad_crc();
    test_length();
    test_gap();
    test_eop_idle();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
